// File: rtl/cmd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cmd_pkg
// Description : Command and state encodings shared by the IP block and cmd_exec
//               so both ends decode com identically.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_pkg;

    localparam int COM_W  = 2;
    localparam int ADDR_W = 4;

    typedef enum logic [COM_W-1:0] {
        CMD_NOP = 2'b00,
        CMD_INC = 2'b01,
        CMD_IF  = 2'b10,
        CMD_DEC = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cmd_exec.sv
`default_nettype none
// ============================================================================
// Module      : cmd_exec
// Description : Executes commands fetched from the instruction-pointer block on
//               an accumulator and drives the IP's jump/advance strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_exec
    import cmd_pkg::*;
#(
    parameter int ACC_W     = 8,
    parameter int LIMIT     = 3,
    parameter int MAX_STEPS = 16,
    parameter int STEP_W    = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [COM_W-1:0]  com,
    input  logic [ADDR_W-1:0] memaddr,
    output logic              set,
    output logic              next,
    output logic [ACC_W-1:0]  acc,
    output logic [STEP_W-1:0] steps,
    output logic [3:0]        jumps,
    output logic              busy,
    output logic              done
);

    localparam logic [ACC_W-1:0]  c_limit     = ACC_W'(LIMIT);
    localparam logic [ACC_W-1:0]  c_acc_one   = ACC_W'(1);
    localparam logic [STEP_W-1:0] c_step_one  = STEP_W'(1);
    localparam logic [STEP_W-1:0] c_max_steps = STEP_W'(MAX_STEPS);

    state_t              r_state;
    cmd_t                r_cmd;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_set;
    logic                r_next;
    logic [ACC_W-1:0]    r_acc;
    logic [STEP_W-1:0]   r_steps;
    logic [3:0]          r_jumps;
    logic                r_busy;
    logic                r_done;

    cmd_t                w_cmd;
    logic                w_take;
    logic [STEP_W-1:0]   w_steps_inc;
    logic                w_unused_addr;

    // The branch decision is made while the IF word is still addressed, so the
    // strobes can be registered on the edge entering EXEC.
    assign w_cmd         = cmd_t'(com);
    assign w_take        = (w_cmd == CMD_IF) && (r_acc < c_limit);
    assign w_steps_inc   = r_steps + c_step_one;
    assign w_unused_addr = ^r_addr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cmd   <= CMD_NOP;
            r_addr  <= '0;
            r_set   <= 1'b0;
            r_next  <= 1'b0;
            r_acc   <= '0;
            r_steps <= '0;
            r_jumps <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_acc   <= '0;
                        r_steps <= '0;
                        r_jumps <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_cmd   <= w_cmd;
                    r_addr  <= memaddr;
                    r_set   <= w_take;
                    r_next  <= ~w_take;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_set   <= 1'b0;
                    r_next  <= 1'b0;
                    r_steps <= w_steps_inc;
                    case (r_cmd)
                        CMD_INC: r_acc <= r_acc + c_acc_one;
                        CMD_DEC: if (r_acc != '0) r_acc <= r_acc - c_acc_one;
                        CMD_IF:  if (r_set && (r_jumps != 4'hF)) r_jumps <= r_jumps + 4'd1;
                        CMD_NOP: r_acc <= r_acc;
                    endcase
                    if (w_steps_inc == c_max_steps) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign set   = r_set;
    assign next  = r_next;
    assign acc   = r_acc;
    assign steps = r_steps;
    assign jumps = r_jumps;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cmd_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_exec
// Description : Directed bench for cmd_exec with a small IP/ROM model as the
//               program source, plus a long-run instance for accumulator wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_exec;
    import cmd_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] com;
    logic [3:0] memaddr;
    logic       set, next, busy, done;
    logic [7:0] acc;
    logic [4:0] steps;
    logic [3:0] jumps;

    logic       start_l;
    logic [1:0] com_l;
    logic [3:0] memaddr_l;
    logic       set_l, next_l, busy_l, done_l;
    logic [7:0] acc_l;
    logic [8:0] steps_l;
    logic [3:0] jumps_l;

    // IP block model: ROM of {com, memaddr} words and a pointer driven by the strobes
    logic [5:0] rom [16];
    logic [3:0] ip = 4'd0;
    logic       ip_load;
    logic [3:0] ip_load_val;
    logic       force_en;
    logic [1:0] force_com;

    int n_checks = 0;
    int n_pass   = 0;

    assign com     = force_en ? force_com : rom[ip][5:4];
    assign memaddr = rom[ip][3:0];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ip_load)   ip <= ip_load_val;
        else if (set)  ip <= memaddr;
        else if (next) ip <= ip + 4'd1;
    end

    cmd_exec u_dut (
        .clock(clock), .reset_n(reset_n), .start(start), .com(com), .memaddr(memaddr),
        .set(set), .next(next), .acc(acc), .steps(steps), .jumps(jumps),
        .busy(busy), .done(done)
    );

    cmd_exec #(.STEP_W(9), .MAX_STEPS(256)) u_long (
        .clock(clock), .reset_n(reset_n), .start(start_l), .com(com_l), .memaddr(memaddr_l),
        .set(set_l), .next(next_l), .acc(acc_l), .steps(steps_l), .jumps(jumps_l),
        .busy(busy_l), .done(done_l)
    );

    task automatic load_ip(input logic [3:0] v);
        @(negedge clock); ip_load = 1'b1; ip_load_val = v;
        @(negedge clock); ip_load = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if ({set, next, busy, done} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {set, next, busy, done}); else n_pass++;
        n_checks++; if ({acc, steps, jumps} !== 17'd0) $display("FAIL reset_regs: got acc=%0d steps=%0d jumps=%0d want 0", acc, steps, jumps); else n_pass++;
        n_checks++; if ({busy_l, done_l, acc_l, steps_l} !== 19'd0) $display("FAIL reset_long: got busy=%b done=%b acc=%0d steps=%0d want 0", busy_l, done_l, acc_l, steps_l); else n_pass++;
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_hold: got busy=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_program();
        int done_k, sets, strobe_err;
        done_k = 0; sets = 0; strobe_err = 0;
        force_en = 1'b0;
        load_ip(4'd0);
        @(negedge clock); start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (set && next) strobe_err++;
            if (busy && (k % 2 == 0)) begin
                if (!(set ^ next)) strobe_err++;
            end else if (set || next) begin
                strobe_err++;
            end
            if (set) sets++;
            if (done) begin done_k = k; break; end
        end
        n_checks++; if (done_k !== 33) $display("FAIL prog_done_cycle: got %0d want 33", done_k); else n_pass++;
        n_checks++; if (sets !== 2) $display("FAIL prog_set_pulses: got %0d want 2", sets); else n_pass++;
        n_checks++; if (strobe_err !== 0) $display("FAIL prog_strobes: got %0d bad cycles want 0", strobe_err); else n_pass++;
        n_checks++; if (acc !== 8'd1) $display("FAIL prog_acc: got %0d want 1", acc); else n_pass++;
        n_checks++; if (jumps !== 4'd2) $display("FAIL prog_jumps: got %0d want 2", jumps); else n_pass++;
        n_checks++; if (steps !== 5'd16) $display("FAIL prog_steps: got %0d want 16", steps); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL prog_busy: got %b want 0", busy); else n_pass++;
        @(negedge clock);
        n_checks++; if ({done, busy, set, next} !== 4'b1000) $display("FAIL prog_done_hold: got %b want 1000", {done, busy, set, next}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int found;
        found = 0;
        force_en = 1'b1; force_com = CMD_INC;
        @(negedge clock); start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            start = 1'b0;
            if ((set || next) && steps == 5'd3) begin found = 1; break; end
        end
        n_checks++; if (found !== 1 || acc !== 8'd3) $display("FAIL rstmid_setup: got found=%0d acc=%0d want 1/3", found, acc); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if ({set, next, busy, done} !== 4'b0000) $display("FAIL rstmid_flags: got %b want 0000", {set, next, busy, done}); else n_pass++;
        n_checks++; if ({acc, steps} !== 13'd0) $display("FAIL rstmid_regs: got acc=%0d steps=%0d want 0", acc, steps); else n_pass++;
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock);
        n_checks++; if ({busy, steps} !== 6'd0) $display("FAIL rstmid_idle: got busy=%b steps=%0d want 0", busy, steps); else n_pass++;
    endtask

    task automatic test_saturation();
        int done_k;
        done_k = 0;
        force_en = 1'b1; force_com = CMD_DEC;
        @(negedge clock); start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (done) begin done_k = k; break; end
        end
        n_checks++; if (done_k !== 33) $display("FAIL sat_done_cycle: got %0d want 33", done_k); else n_pass++;
        n_checks++; if (acc !== 8'd0) $display("FAIL sat_dec_floor: got %0d want 0", acc); else n_pass++;
    endtask

    task automatic test_wrap();
        int seen_ff;
        seen_ff = 0;
        com_l = CMD_INC;
        @(negedge clock); start_l = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clock);
            start_l = 1'b0;
            if (steps_l == 9'd255 && seen_ff == 0) begin
                seen_ff = 1;
                n_checks++; if (acc_l !== 8'hFF) $display("FAIL wrap_ff: got %h want ff", acc_l); else n_pass++;
            end
            if (done_l) break;
        end
        n_checks++; if (seen_ff !== 1) $display("FAIL wrap_reach_255: got %0d want 1", seen_ff); else n_pass++;
        n_checks++; if ({done_l, acc_l} !== 9'h100) $display("FAIL wrap_zero: got done=%b acc=%h want 1/00", done_l, acc_l); else n_pass++;
        n_checks++; if (steps_l !== 9'd256) $display("FAIL wrap_steps: got %0d want 256", steps_l); else n_pass++;
    endtask

    task automatic test_start_held();
        int done_k, restart_err;
        logic [4:0] prev;
        done_k = 0; restart_err = 0; prev = 5'd0;
        force_en = 1'b1; force_com = CMD_INC;
        @(negedge clock); start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (steps < prev) restart_err++;
            prev = steps;
            if (done) begin done_k = k; break; end
        end
        n_checks++; if (done_k !== 33) $display("FAIL held_done_cycle: got %0d want 33", done_k); else n_pass++;
        n_checks++; if (restart_err !== 0) $display("FAIL held_no_restart: got %0d want 0", restart_err); else n_pass++;
        n_checks++; if (acc !== 8'd16) $display("FAIL held_acc: got %0d want 16", acc); else n_pass++;
        @(negedge clock);
        start = 1'b0;
        n_checks++; if ({busy, done} !== 2'b10) $display("FAIL held_restart_flags: got %b want 10", {busy, done}); else n_pass++;
        n_checks++; if ({acc, steps} !== 13'd0) $display("FAIL held_restart_clear: got acc=%0d steps=%0d want 0", acc, steps); else n_pass++;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done) break;
        end
        n_checks++; if ({done, acc} !== 9'h110) $display("FAIL held_second_run: got done=%b acc=%0d want 1/16", done, acc); else n_pass++;
    endtask

    task automatic test_if_limit();
        int done_k;
        done_k = 0;
        for (int i = 0; i < 16; i++) rom[i] = 6'b00_0000;
        rom[0] = 6'b01_0000; rom[1] = 6'b01_0000; rom[2] = 6'b01_0000; rom[3] = 6'b10_1010;
        force_en = 1'b0;
        load_ip(4'd0);
        @(negedge clock); start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (k == 8) begin
                n_checks++; if ({set, next} !== 2'b01) $display("FAIL iflim_strobe: got set=%b next=%b want 0/1", set, next); else n_pass++;
                n_checks++; if (acc !== 8'd3) $display("FAIL iflim_acc: got %0d want 3", acc); else n_pass++;
            end
            if (k == 9) begin
                n_checks++; if (ip !== 4'd4) $display("FAIL iflim_ip: got %0d want 4", ip); else n_pass++;
            end
            if (done) begin done_k = k; break; end
        end
        n_checks++; if (done_k !== 33) $display("FAIL iflim_done_cycle: got %0d want 33", done_k); else n_pass++;
        n_checks++; if (jumps !== 4'd0) $display("FAIL iflim_jumps: got %0d want 0", jumps); else n_pass++;
    endtask

    initial begin
        start = 1'b0; start_l = 1'b0; com_l = CMD_NOP; memaddr_l = 4'h0;
        force_en = 1'b0; force_com = CMD_NOP;
        ip_load = 1'b1; ip_load_val = 4'd0;
        for (int i = 0; i < 16; i++) rom[i] = 6'b00_0000;
        rom[2] = 6'b01_0000;
        rom[3] = 6'b10_0010;
        rom[4] = 6'b11_0000;
        rom[5] = 6'b11_0000;
        test_reset();
        ip_load = 1'b0;
        test_program();
        test_reset_mid();
        test_saturation();
        test_wrap();
        test_start_held();
        test_if_limit();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
